dconv_k1_pipe: RTL and testbench
================================

// Module: dconv_k1_pipe
// PURPOSE
//  Depthwise 1x1 convolution, INPUT_CHANNEL lanes in parallel, one pixel per beat.
//  Per lane: signed x*w + bias, rounded arithmetic right shift, saturate to N bits.
//  3-stage pipeline with valid/ready backpressure and a frame counter that flags the last pixel.
//  Sits between feature-map streamers and the next conv/pool stage in the nn datapath.
// PARAMETERS
//  N              8   data/weight width, signed two's complement
//  INPUT_CHANNEL  3   parallel channel lanes
//  INPUT_SIZE     6   frame is INPUT_SIZE*INPUT_SIZE pixels
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  async reset, active low
//  input_vld      in   1                  input beat valid
//  input_rdy      out  1                  block accepts beat this cycle
//  input_din      in   INPUT_CHANNEL*N    pixel, lane i at [N*i +: N]
//  weight_din     in   INPUT_CHANNEL*N    weights, lane i at [N*i +: N]
//  bias_din       in   INPUT_CHANNEL*32   signed biases, lane i at [32*i +: 32]
//  shift_din      in   INPUT_CHANNEL*5    unsigned right shift 0..31 per lane
//  conv_dout      out  INPUT_CHANNEL*N    result, lane i at [N*i +: N]
//  conv_dout_vld  out  1                  output beat valid
//  conv_dout_rdy  in   1                  downstream accepts output
//  conv_dout_end  out  1                  qualifies last pixel of frame (only with conv_dout_vld)
// BEHAVIOUR
//  - One clock clk; reset rst_n asynchronous, active low.
//  - Reset: conv_dout=0, conv_dout_vld=0, conv_dout_end=0, all stage valids=0, pixel counter=0.
//  - adv = ~conv_dout_vld | conv_dout_rdy; input_rdy = adv (combinational). All stages move on adv.
//  - Accept when input_vld & input_rdy; weight/bias/shift sampled on the same beat as input_din.
//  - S1: prod = x*w, 2N-bit signed. S2: acc = sext33(prod) + sext33(bias).
//  - S3: if shift>0, r = (acc + (1<<(shift-1))) >>> shift, else r = acc; 33-bit signed math.
//    saturate r to [-2^(N-1), 2^(N-1)-1] -> conv_dout lane.
//  - Latency 3 cycles accept->conv_dout_vld with no stall; throughput 1 beat/cycle.
//  - Bubbles propagate as invalid stages; stage registers hold when adv=0 (no loss, no duplication).
//  - conv_dout, conv_dout_vld, conv_dout_end stable while conv_dout_vld & ~conv_dout_rdy.
//  - Pixel counter 0..INPUT_SIZE^2-1 tracks the tag of the beat in S3; conv_dout_end=1 when
//    counter==INPUT_SIZE^2-1; counter increments on output handshake, wraps to 0 after last.
//  - Simultaneous output handshake and new input accept in same cycle: both occur.
//  - Reset mid-frame: pipeline flushed, counter cleared; next accepted beat is pixel 0.
//  - All lanes share one control path; conv_dout_vld/end are common to all lanes.
// CONFIGURATION
//  DCONV_K1_RELU_EN defined: after saturation, negative lane results forced to 0 (ReLU fused).
//  Not defined: saturated signed result passed through unchanged.
// TESTING  (N=8, INPUT_CHANNEL=3, INPUT_SIZE=2, conv_dout_rdy=1 unless stated)
//  1 x=10,w=3,b=5,shift=1 all lanes -> (35+1)>>>1=18 each lane, vld exactly 3 cycles after accept.
//  2 x=127,w=127,b=0,sh=0 -> 127; x=-128,w=127,b=0,sh=0 -> -128; x=-3,w=1,b=0,sh=1 -> -1.
//  3 8 back-to-back beats -> 8 outputs in order, conv_dout_end high on 4th and 8th only.
//  4 rdy low 5 cycles mid-stream -> input_rdy low, outputs held stable, no beat lost/duplicated.
//  5 rst_n pulsed after 2 of 4 beats -> outputs 0 at once; next frame's 4th output raises end.
//  6 x=-3,w=1,b=0,sh=1 with DCONV_K1_RELU_EN -> 0; without -> -1 (0xFF).

Source files
------------

// File: rtl/dconv_k1_pipe.sv
// dconv_k1_pipe: depthwise 1x1 conv, per-lane x*w+bias, rounded shift, saturate; 3-stage valid/ready pipe.
// Define DCONV_K1_RELU_EN to clamp negative lane results to zero after saturation.
module dconv_k1_pipe #(
  parameter int N             = 8,
  parameter int INPUT_CHANNEL = 3,
  parameter int INPUT_SIZE    = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       input_vld,
  output logic                       input_rdy,
  input  logic [INPUT_CHANNEL*N-1:0] input_din,
  input  logic [INPUT_CHANNEL*N-1:0] weight_din,
  input  logic [INPUT_CHANNEL*32-1:0] bias_din,
  input  logic [INPUT_CHANNEL*5-1:0] shift_din,
  output logic [INPUT_CHANNEL*N-1:0] conv_dout,
  output logic                       conv_dout_vld,
  input  logic                       conv_dout_rdy,
  output logic                       conv_dout_end
);
  localparam int LAST = INPUT_SIZE*INPUT_SIZE-1;
  localparam int CW = (LAST > 0) ? $clog2(LAST+1) : 1;
  localparam logic signed [32:0] HI = 2**(N-1)-1;
  localparam logic signed [32:0] LO = -(2**(N-1));
  logic adv, v1, v2;
  logic [CW-1:0] cnt;
  assign adv = ~conv_dout_vld | conv_dout_rdy;
  assign input_rdy = adv;
  assign conv_dout_end = conv_dout_vld && (cnt == CW'(LAST));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      conv_dout_vld <= 1'b0;
      cnt <= '0;
    end else begin
      if (adv) begin
        v1 <= input_vld;
        v2 <= v1;
        conv_dout_vld <= v2;
      end
      if (conv_dout_vld && conv_dout_rdy) cnt <= (cnt == CW'(LAST)) ? '0 : cnt + 1'b1;
    end
  end
  for (genvar i = 0; i < INPUT_CHANNEL; i++) begin : g_lane
    logic signed [2*N-1:0] p1;
    logic signed [31:0] b1;
    logic [4:0] s1, s2;
    logic signed [32:0] a2, rnd, r;
    logic signed [N-1:0] sat, res, o;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1 <= '0;
        b1 <= '0;
        s1 <= '0;
        a2 <= '0;
        s2 <= '0;
        o <= '0;
      end else if (adv) begin
        p1 <= $signed(input_din[N*i +: N]) * $signed(weight_din[N*i +: N]);
        b1 <= $signed(bias_din[32*i +: 32]);
        s1 <= shift_din[5*i +: 5];
        a2 <= {{(33-2*N){p1[2*N-1]}}, p1} + {b1[31], b1};
        s2 <= s1;
        o <= res;
      end
    end
    // half-LSB rounding bias only exists for a nonzero shift
    always_comb begin
      rnd = (s2 == 5'd0) ? '0 : (33'sd1 <<< (s2 - 5'd1));
      r = (a2 + rnd) >>> s2;
      sat = (r > HI) ? HI[N-1:0] : (r < LO) ? LO[N-1:0] : r[N-1:0];
`ifdef DCONV_K1_RELU_EN
      res = sat[N-1] ? '0 : sat;
`else
      res = sat;
`endif
    end
    assign conv_dout[N*i +: N] = o;
  end
endmodule

// File: tb/tb_dconv_k1_pipe.sv
// tb_dconv_k1_pipe: directed checks of dconv_k1_pipe (N=8, 3 lanes, 2x2 frame).
module tb_dconv_k1_pipe;
  localparam int N = 8, C = 3, S = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic input_vld = 1'b0, input_rdy, conv_dout_vld, conv_dout_rdy = 1'b1, conv_dout_end;
  logic [C*N-1:0] input_din = '0, weight_din = '0, conv_dout;
  logic [C*32-1:0] bias_din = '0;
  logic [C*5-1:0] shift_din = '0;
  int tests = 0, fails = 0;
  int sent, got;
  logic stall, acc;
  logic [C*N-1:0] held;
`ifdef DCONV_K1_RELU_EN
  localparam logic [23:0] EXP_A = 24'h00007F, EXP_B = 24'h00004B;
`else
  localparam logic [23:0] EXP_A = 24'hFF807F, EXP_B = 24'h00F04B;
`endif

  always #5 clk = ~clk;

  dconv_k1_pipe #(.N(N), .INPUT_CHANNEL(C), .INPUT_SIZE(S)) dut (
    .clk(clk), .rst_n(rst_n), .input_vld(input_vld), .input_rdy(input_rdy),
    .input_din(input_din), .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
    .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld), .conv_dout_rdy(conv_dout_rdy),
    .conv_dout_end(conv_dout_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int i, input logic [7:0] x, input logic [7:0] w, input logic [31:0] b, input logic [4:0] s);
    input_din[N*i +: N] = x;
    weight_din[N*i +: N] = w;
    bias_din[32*i +: 32] = b;
    shift_din[5*i +: 5] = s;
  endtask

  task automatic lanes(input logic [7:0] x, input logic [7:0] w, input logic [31:0] b, input logic [4:0] s);
    for (int i = 0; i < C; i++) lane(i, x, w, b, s);
  endtask

  function automatic logic [31:0] rep(input logic [7:0] v);
    return {8'h00, v, v, v};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    input_vld = 1'b0;
    conv_dout_rdy = 1'b1;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_dout", 32'(conv_dout), 32'h0);
    chk("rst_vld", 32'(conv_dout_vld), 32'h0);
    chk("rst_end", 32'(conv_dout_end), 32'h0);
    chk("rst_in_rdy", 32'(input_rdy), 32'h1);
    tick;
    rst_n = 1'b1;
    // latency and basic rounding
    lanes(8'd10, 8'd3, 32'd5, 5'd1);
    input_vld = 1'b1;
    #1 chk("t1_in_rdy", 32'(input_rdy), 32'h1);
    tick;
    input_vld = 1'b0;
    #1 chk("t1_lat1_vld", 32'(conv_dout_vld), 32'h0);
    tick;
    #1 chk("t1_lat2_vld", 32'(conv_dout_vld), 32'h0);
    tick;
    #1 chk("t1_lat3_vld", 32'(conv_dout_vld), 32'h1);
    chk("t1_dout", 32'(conv_dout), rep(8'd18));
    chk("t1_end", 32'(conv_dout_end), 32'h0);
    // saturation, negative rounding, large shift
    do_reset;
    lane(0, 8'd127, 8'd127, 32'd0, 5'd0);
    lane(1, 8'h80, 8'd127, 32'd0, 5'd0);
    lane(2, 8'hFD, 8'd1, 32'd0, 5'd1);
    input_vld = 1'b1;
    tick;
    lane(0, 8'd50, 8'd50, -32'sd100, 5'd5);
    lane(1, 8'hF9, 8'd9, 32'd0, 5'd2);
    lane(2, 8'd0, 8'd0, 32'd1000, 5'd31);
    tick;
    input_vld = 1'b0;
    tick;
    #1 chk("t2_vld_a", 32'(conv_dout_vld), 32'h1);
    chk("t2_dout_a", 32'(conv_dout), {8'h00, EXP_A});
    tick;
    #1 chk("t2_vld_b", 32'(conv_dout_vld), 32'h1);
    chk("t2_dout_b", 32'(conv_dout), {8'h00, EXP_B});
    // back-to-back stream, end on every 4th output
    do_reset;
    for (int c = 0; c <= 10; c++) begin
      input_vld = (c < 8);
      lanes(8'(c + 1), 8'd1, 32'd0, 5'd0);
      tick;
      if (c >= 2 && c <= 9) begin
        chk("t3_vld", 32'(conv_dout_vld), 32'h1);
        chk("t3_dout", 32'(conv_dout), rep(8'(c - 1)));
        chk("t3_end", 32'(conv_dout_end), 32'((c - 2) % 4 == 3));
      end else chk("t3_idle_vld", 32'(conv_dout_vld), 32'h0);
    end
    // downstream stall mid-stream
    do_reset;
    sent = 0;
    got = 0;
    stall = 1'b0;
    held = '0;
    for (int c = 0; c <= 24; c++) begin
      conv_dout_rdy = !(c >= 4 && c < 9);
      input_vld = (sent < 6);
      lanes(8'(sent + 1), 8'd1, 32'd0, 5'd0);
      #1;
      if (stall) begin
        chk("t4_hold_vld", 32'(conv_dout_vld), 32'h1);
        chk("t4_hold_dout", 32'(conv_dout), 32'(held));
      end
      if (!conv_dout_rdy && conv_dout_vld) chk("t4_in_rdy", 32'(input_rdy), 32'h0);
      stall = conv_dout_vld & ~conv_dout_rdy;
      held = conv_dout;
      if (conv_dout_vld && conv_dout_rdy) begin
        chk("t4_dout", 32'(conv_dout), rep(8'(got + 1)));
        chk("t4_end", 32'(conv_dout_end), 32'(got % 4 == 3));
        got++;
      end
      acc = input_vld & input_rdy;
      tick;
      if (acc) sent++;
    end
    chk("t4_sent", 32'(sent), 32'd6);
    chk("t4_got", 32'(got), 32'd6);
    // asynchronous reset mid-frame
    do_reset;
    lanes(8'd1, 8'd1, 32'd0, 5'd0);
    input_vld = 1'b1;
    tick;
    lanes(8'd2, 8'd1, 32'd0, 5'd0);
    tick;
    input_vld = 1'b0;
    tick;
    #1 chk("t5_pre_dout0", 32'(conv_dout), rep(8'd1));
    tick;
    #1 chk("t5_pre_dout1", 32'(conv_dout), rep(8'd2));
    chk("t5_pre_end", 32'(conv_dout_end), 32'h0);
    rst_n = 1'b0;
    #1 chk("t5_rst_dout", 32'(conv_dout), 32'h0);
    chk("t5_rst_vld", 32'(conv_dout_vld), 32'h0);
    chk("t5_rst_end", 32'(conv_dout_end), 32'h0);
    tick;
    rst_n = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      input_vld = (c < 4);
      lanes(8'(c + 11), 8'd1, 32'd0, 5'd0);
      tick;
      if (c >= 2 && c <= 5) begin
        chk("t5_vld", 32'(conv_dout_vld), 32'h1);
        chk("t5_dout", 32'(conv_dout), rep(8'(c + 9)));
        chk("t5_end", 32'(conv_dout_end), 32'(c == 5));
      end else chk("t5_idle_vld", 32'(conv_dout_vld), 32'h0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
